led_bank_arbiter: RTL and testbench

- Shares the board's single positive-logic LED bank between up to NREQ requester blocks (counters, status monitors, debug patterns).
- Arbitration is round-robin. Each winner owns the bank for at most HOLD_TICKS clocks.
- A one-clock dark gap separates owners.
- Intended clock is the slow OSCTIMER-derived clk, so each grant is visible to a human. The top level inverts `led` onto the active-low pins.

---
 rtl/led_bank_arbiter.sv | 165 ++++++++++++++++
 tb/tb_led_bank_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing one positive-logic LED bank between several requesters.
// Each winner owns the bank for at most HOLD_TICKS clocks. A one-clock dark gap
// separates consecutive owners. All outputs are registered.
module led_bank_arbiter #(
    parameter int unsigned      NREQ         = 4,
    parameter int unsigned      LED_W        = 8,
    parameter int unsigned      HOLD_TICKS   = 4,
    parameter logic [LED_W-1:0] IDLE_PATTERN = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LED_W-1:0] pat,
    output logic [NREQ-1:0]       grant,
    output logic [LED_W-1:0]      led,
    output logic [2:0]            owner,
    output logic                  busy
);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StGap
    } state_e;

    localparam logic [7:0] CntLoad = 8'(HOLD_TICKS - 1);
    localparam logic [2:0] LastIdx = 3'(NREQ - 1);

    state_e           state_q, state_d;
    logic [NREQ-1:0]  grant_q, grant_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [2:0]       owner_q, owner_d;
    logic             busy_q, busy_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [7:0]       cnt_q, cnt_d;

    logic             win_valid;
    logic [2:0]       win_idx;
    logic [2:0]       pos;
    logic [LED_W-1:0] win_pat;
    logic [LED_W-1:0] own_pat;
    logic             own_req;
    logic [2:0]       ptr_after_owner;

    // Round-robin search: first set request starting at ptr, wrapping NREQ-1 -> 0.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        pos       = ptr_q;
        for (int k = 0; k < int'(NREQ); k++) begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (!win_valid && req[i] && (pos == 3'(i))) begin
                    win_valid = 1'b1;
                    win_idx   = 3'(i);
                end
            end
            pos = (pos == LastIdx) ? 3'd0 : pos + 3'd1;
        end
    end

    // Select patterns and the owner's request by decoded index, so unused
    // index values never reach a part-select and no X can leak out.
    always_comb begin
        win_pat = '0;
        own_pat = '0;
        own_req = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (win_idx == 3'(i)) begin
                win_pat = pat[i*LED_W +: LED_W];
            end
            if (owner_q == 3'(i)) begin
                own_pat = pat[i*LED_W +: LED_W];
                own_req = req[i];
            end
        end
    end

    // Pointer position just past the current owner.
    always_comb begin
        ptr_after_owner = (owner_q == LastIdx) ? 3'd0 : owner_q + 3'd1;
    end

    // Next-state and next-output logic for the IDLE/GRANT/GAP machine.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        led_d   = led_q;
        owner_d = owner_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StGrant: begin
                if ((cnt_q == 8'd0) || !own_req) begin
                    state_d = StGap;
                    grant_d = '0;
                    led_d   = IDLE_PATTERN;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_after_owner;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    // Follow the owner's live pattern with one clock of lag.
                    led_d = own_pat;
                end
            end
            StIdle, StGap: begin
                // GAP lasts a single clock: arbitration always runs on its edge.
                if (win_valid) begin
                    state_d = StGrant;
                    for (int i = 0; i < int'(NREQ); i++) begin
                        grant_d[i] = (win_idx == 3'(i));
                    end
                    owner_d = win_idx;
                    led_d   = win_pat;
                    busy_d  = 1'b1;
                    cnt_d   = CntLoad;
                end else begin
                    state_d = StIdle;
                    grant_d = '0;
                    led_d   = IDLE_PATTERN;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                led_d   = IDLE_PATTERN;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            led_q   <= IDLE_PATTERN;
            owner_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            led_q   <= led_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant = grant_q;
    assign led   = led_q;
    assign owner = owner_q;
    assign busy  = busy_q;

    // Structural invariants of the registered outputs.
    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
    a_busy_grant:   assert property (@(posedge clk) disable iff (rst) busy_q == (grant_q != '0));
    a_dark_idle:    assert property (@(posedge clk) disable iff (rst)
                                     !busy_q |-> (led_q == IDLE_PATTERN));

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Randomized bench for led_bank_arbiter: two instances (4 requesters / hold 4 and
// 3 requesters / hold 1 with a non-zero idle pattern) against a behavioural model.
module tb_led_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] pat = '0;

    logic [3:0]  grant_a;
    logic [7:0]  led_a;
    logic [2:0]  owner_a;
    logic        busy_a;
    logic [2:0]  grant_b;
    logic [7:0]  led_b;
    logic [2:0]  owner_b;
    logic        busy_b;

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 idle, 1 owned, 2 dark gap.
    int         m_ph[2];
    int         m_own[2];
    int         m_ptr[2];
    int         m_held[2];
    logic [7:0] m_led[2];
    logic [3:0] m_gnt[2];

    led_bank_arbiter #(
        .NREQ(4), .LED_W(8), .HOLD_TICKS(4), .IDLE_PATTERN(8'h00)
    ) dut_a (
        .clk(clk), .rst(rst), .req(req), .pat(pat),
        .grant(grant_a), .led(led_a), .owner(owner_a), .busy(busy_a)
    );

    led_bank_arbiter #(
        .NREQ(3), .LED_W(8), .HOLD_TICKS(1), .IDLE_PATTERN(8'h5A)
    ) dut_b (
        .clk(clk), .rst(rst), .req(req[2:0]), .pat(pat[23:0]),
        .grant(grant_b), .led(led_b), .owner(owner_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // One clock of the reference behaviour for instance d, using inputs at the edge.
    task automatic model_step(input int d);
        int         n;
        int         h;
        int         w;
        int         idx;
        logic [7:0] idle;
        n    = (d == 0) ? 4 : 3;
        h    = (d == 0) ? 4 : 1;
        idle = (d == 0) ? 8'h00 : 8'h5A;
        if (rst) begin
            m_ph[d]   = 0;
            m_own[d]  = 0;
            m_ptr[d]  = 0;
            m_held[d] = 0;
            m_gnt[d]  = '0;
            m_led[d]  = idle;
        end else if (m_ph[d] == 1) begin
            if (m_held[d] >= h || !req[m_own[d]]) begin
                m_ph[d]  = 2;
                m_gnt[d] = '0;
                m_led[d] = idle;
                m_ptr[d] = (m_own[d] + 1) % n;
            end else begin
                m_held[d] = m_held[d] + 1;
                m_led[d]  = pat[m_own[d]*8 +: 8];
            end
        end else begin
            w = -1;
            for (int k = 0; k < n; k++) begin
                idx = (m_ptr[d] + k) % n;
                if (w < 0 && req[idx]) w = idx;
            end
            if (w < 0) begin
                m_ph[d]  = 0;
                m_gnt[d] = '0;
                m_led[d] = idle;
            end else begin
                m_ph[d]   = 1;
                m_own[d]  = w;
                m_held[d] = 1;
                m_gnt[d]  = 4'(1 << w);
                m_led[d]  = pat[w*8 +: 8];
            end
        end
    endtask

    task automatic compare_all();
        check("a_grant", 32'(grant_a), 32'(m_gnt[0]));
        check("a_led",   32'(led_a),   32'(m_led[0]));
        check("a_owner", 32'(owner_a), m_own[0]);
        check("a_busy",  32'(busy_a),  32'(m_ph[0] == 1));
        check("b_grant", 32'(grant_b), 32'(m_gnt[1]));
        check("b_led",   32'(led_b),   32'(m_led[1]));
        check("b_owner", 32'(owner_b), m_own[1]);
        check("b_busy",  32'(busy_b),  32'(m_ph[1] == 1));
    endtask

    // Advance one clock, update the model at the edge, compare just after it.
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    initial begin
        // Power-on reset, released between edges.
        cycle();
        cycle();
        #1 rst = 1'b0;

        // Full contention with distinct patterns.
        pat = 32'h4433_2211;
        req = 4'b1111;
        repeat (22) cycle();

        // Sole persistent requester.
        pat = 32'h4433_22A5;
        req = 4'b0001;
        repeat (12) cycle();

        // Early release of requester 0 while requester 1 waits.
        req = 4'b0011;
        repeat (3) cycle();
        req = 4'b0010;
        repeat (8) cycle();

        // Live pattern change while requester 2 owns the bank.
        pat = 32'h440F_2211;
        req = 4'b0100;
        repeat (2) cycle();
        pat = 32'h44F0_2211;
        repeat (3) cycle();

        // Random traffic: requests and patterns change sporadically.
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom);
            if ($urandom_range(2) == 0) pat = $urandom;
            cycle();
        end

        // Reset mid-run with everything requesting: outputs clear without waiting for an edge.
        req = 4'b1111;
        repeat (6) cycle();
        #2 rst = 1'b1;
        #1;
        check("rst_a_grant", 32'(grant_a), 32'h0);
        check("rst_a_led",   32'(led_a),   32'h00);
        check("rst_a_owner", 32'(owner_a), 32'h0);
        check("rst_a_busy",  32'(busy_a),  32'h0);
        check("rst_b_grant", 32'(grant_b), 32'h0);
        check("rst_b_led",   32'(led_b),   32'h5A);
        check("rst_b_owner", 32'(owner_b), 32'h0);
        check("rst_b_busy",  32'(busy_b),  32'h0);
        cycle();
        cycle();
        #1 rst = 1'b0;
        cycle();
        check("post_rst_first_grant", 32'(grant_a), 32'h1);
        repeat (10) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
